// File: rtl/lsu_mw_stage.sv
// Memory/writeback stage: runs loads and stores on a req/gnt/rvalid data bus,
// aligns and extends load data, and drives the regfile write port.
module lsu_mw_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_mw,
  input  logic [31:0] alu_res_mw,
  input  logic [31:0] rdata2_mw,
  input  logic [4:0]  waddr_mw,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic        reg_wr,
  input  logic [1:0]  wb_sel,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_mw,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_exc,
  output logic [1:0]  exc_cause
);

  // state | meaning
  // IDLE  | no access in flight; ALU writeback or launch of a memop
  // REQ   | dbus_req held until gnt
  // RSP   | waiting for rvalid
  // DONE  | load writeback; pipeline advances
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_we, r_regwr;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [1:0]  r_off, r_cause;
  logic [7:0]  r_cnt;

  logic        w_memop, w_f3_legal, w_misal, w_launch, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;
  logic [7:0]  w_byte, w_cnt_inc;
  logic [15:0] w_half;
  logic [1:0]  w_cause;

  assign w_memop    = mem_rd | mem_wr;
  assign w_f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_misal    = ((funct3[1:0] == 2'b01) & alu_res_mw[0]) |
                      ((funct3[1:0] == 2'b10) & (alu_res_mw[1:0] != 2'b00));
  assign w_launch   = (r_state == S_IDLE) & w_memop & w_f3_legal & ~w_misal & ~rst;
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_timeout  = (w_cnt_inc == TO_LIM) &
                      (((r_state == S_REQ) & ~dbus_gnt) | ((r_state == S_RSP) & ~dbus_rvalid));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rdata2_mw;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_res_mw[1:0];
        w_wdata = {4{rdata2_mw[7:0]}};
      end
      2'b01: begin
        w_be    = alu_res_mw[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{rdata2_mw[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: ;
    endcase
    w_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    dbus_req    = 1'b0;
    dbus_we     = 1'b0;
    dbus_addr   = 32'd0;
    dbus_be     = 4'd0;
    dbus_wdata  = 32'd0;
    stall_mw    = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    mem_exc     = 1'b0;
    w_cause     = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          if (!w_f3_legal) begin
            mem_exc = 1'b1;
            w_cause = 2'b10;
          end else if (w_misal) begin
            mem_exc = 1'b1;
            w_cause = 2'b01;
          end else begin
            stall_mw    = 1'b1;
            w_state_nxt = S_REQ;
          end
        end else begin
          wb_en   = reg_wr & (waddr_mw != 5'd0);
          wb_addr = waddr_mw;
          case (wb_sel)
            2'b01:   wb_data = w_load_data;
            2'b10:   wb_data = addr_mw + 32'd4;
            default: wb_data = alu_res_mw;
          endcase
        end
      end
      S_REQ: begin
        dbus_req   = 1'b1;
        dbus_we    = r_we;
        dbus_addr  = r_addr;
        dbus_be    = r_be;
        dbus_wdata = r_wdata;
        stall_mw   = 1'b1;
        if (dbus_gnt) begin
          w_state_nxt = S_RSP;
        end else if (w_timeout) begin
          stall_mw    = 1'b0;
          mem_exc     = 1'b1;
          w_cause     = 2'b11;
          w_state_nxt = S_IDLE;
        end
      end
      S_RSP: begin
        stall_mw = 1'b1;
        if (dbus_rvalid) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          stall_mw    = 1'b0;
          mem_exc     = 1'b1;
          w_cause     = 2'b11;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!r_we) begin
          wb_en   = r_regwr & (r_rd != 5'd0);
          wb_addr = r_rd;
          wb_data = w_load_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Outputs are forced quiet during reset, including the input-driven IDLE paths.
    if (rst) begin
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = 32'd0;
      dbus_be    = 4'd0;
      dbus_wdata = 32'd0;
      stall_mw   = 1'b0;
      wb_en      = 1'b0;
      wb_addr    = 5'd0;
      wb_data    = 32'd0;
      mem_exc    = 1'b0;
      w_cause    = 2'b00;
    end
  end

  assign exc_cause = rst ? 2'b00 : (mem_exc ? w_cause : r_cause);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_be    <= 4'd0;
      r_we    <= 1'b0;
      r_regwr <= 1'b0;
      r_f3    <= 3'd0;
      r_rd    <= 5'd0;
      r_off   <= 2'd0;
      r_cause <= 2'b00;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_addr  <= {alu_res_mw[31:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_we    <= mem_wr;
        r_regwr <= reg_wr;
        r_f3    <= funct3;
        r_rd    <= waddr_mw;
        r_off   <= alu_res_mw[1:0];
        r_cnt   <= 8'd0;
      end else if (r_state == S_REQ) begin
        r_cnt <= dbus_gnt ? 8'd0 : w_cnt_inc;
      end else if (r_state == S_RSP) begin
        r_cnt <= w_cnt_inc;
      end
      if ((r_state == S_RSP) && dbus_rvalid) begin
        r_rdata <= dbus_rdata;
      end
      if (mem_exc) begin
        r_cause <= w_cause;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mw_stage.sv
// Self-checking bench for lsu_mw_stage: scenario tasks with a writeback scoreboard.
module tb_lsu_mw_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_mw = 32'd0, alu_res_mw = 32'd0, rdata2_mw = 32'd0;
  logic [4:0]  waddr_mw = 5'd0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, reg_wr = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [1:0]  wb_sel = 2'd0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = 32'd0;
  logic        stall_mw, wb_en, mem_exc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  exc_cause;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;
  wb_t sb_q[$];

  lsu_mw_stage #(.TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .addr_mw(addr_mw), .alu_res_mw(alu_res_mw),
    .rdata2_mw(rdata2_mw), .waddr_mw(waddr_mw), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .reg_wr(reg_wr), .wb_sel(wb_sel),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .stall_mw(stall_mw), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .mem_exc(mem_exc), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] v);
    case (f3[1:0])
      2'b00:   return {4{v[7:0]}};
      2'b01:   return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> (8 * off);
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic set_alu(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                         input logic rw, input logic [1:0] sel);
    mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0;
    addr_mw = pc; alu_res_mw = alu; waddr_mw = rd; reg_wr = rw; wb_sel = sel;
  endtask

  task automatic set_mem(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw);
    mem_rd = rd_; mem_wr = wr_; funct3 = f3; alu_res_mw = a; rdata2_mw = rs2;
    waddr_mw = rd; reg_wr = rw; wb_sel = rd_ ? 2'b01 : 2'b00; addr_mw = 32'h0000_1000;
  endtask

  task automatic do_memop(input logic rd_, input logic wr_, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw, input int gdly, input int rdly,
                          input logic [31:0] rword, input string nm, output int cyc);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        exp_wb;
    wb_t         got, exp;
    ebe    = model_be(f3, a[1:0]);
    ewd    = model_wdata(f3, rs2);
    exp_wb = rd_ & rw & (rd != 5'd0);
    @(negedge clk);
    set_mem(rd_, wr_, f3, a, rs2, rd, rw);
    #1;
    cyc = 1;
    n_tests++;
    if ({stall_mw, dbus_req, wb_en, mem_exc} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s launch: stall/req/wb_en/exc got %b want 1000", nm,
               {stall_mw, dbus_req, wb_en, mem_exc});
    end
    if (exp_wb) sb_q.push_back('{rd, model_load(f3, a[1:0], rword)});
    for (int i = 0; i <= gdly; i++) begin
      @(negedge clk);
      dbus_gnt = (i == gdly);
      #1;
      cyc++;
      n_tests++;
      if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_mw, wb_en, mem_exc} !==
          {1'b1, wr_, {a[31:2], 2'b00}, ebe, ewd, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s req cyc %0d: req=%b we=%b addr=%h be=%b wdata=%h stall=%b want we=%b addr=%h be=%b wdata=%h",
                 nm, i, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_mw,
                 wr_, {a[31:2], 2'b00}, ebe, ewd);
      end
    end
    for (int j = 0; j <= rdly; j++) begin
      @(negedge clk);
      dbus_gnt    = 1'b0;
      dbus_rvalid = (j == rdly);
      dbus_rdata  = (j == rdly) ? rword : $urandom();
      #1;
      cyc++;
      n_tests++;
      if ({dbus_req, stall_mw, wb_en, mem_exc} !== 4'b0100) begin
        n_fail++;
        $display("FAIL %s rsp cyc %0d: req/stall/wb_en/exc got %b want 0100", nm, j,
                 {dbus_req, stall_mw, wb_en, mem_exc});
      end
    end
    @(negedge clk);
    dbus_rvalid = 1'b0;
    dbus_rdata  = $urandom();
    #1;
    cyc++;
    n_tests++;
    if ({stall_mw, dbus_req, mem_exc, wb_en} !== {3'b000, exp_wb}) begin
      n_fail++;
      $display("FAIL %s done: stall/req/exc/wb_en got %b want %b", nm,
               {stall_mw, dbus_req, mem_exc, wb_en}, {3'b000, exp_wb});
    end
    if (wb_en === 1'b1) begin
      n_tests++;
      got = '{wb_addr, wb_data};
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s wb: unexpected write x%0d=%h, want none", nm, wb_addr, wb_data);
      end else begin
        exp = sb_q.pop_front();
        if ({got.a, got.d} !== {exp.a, exp.d}) begin
          n_fail++;
          $display("FAIL %s wb: got x%0d=%h want x%0d=%h", nm, got.a, got.d, exp.a, exp.d);
        end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    set_alu(32'h0000_0100, 32'h0000_1234, 5'd5, 1'b1, 2'b00);
    #1;
    n_tests++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_mw, wb_en, wb_addr, wb_data,
         mem_exc, exc_cause} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: wb_en=%b wb_data=%h req=%b stall=%b, want all 0",
               wb_en, wb_data, dbus_req, stall_mw);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu;
    @(negedge clk);
    set_alu(32'h0000_0100, 32'h0000_1234, 5'd5, 1'b1, 2'b00);
    #1;
    n_tests++;
    if ({wb_en, wb_addr, wb_data, stall_mw, dbus_req, mem_exc, exc_cause} !==
        {1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL alu wb: en=%b x%0d=%h stall=%b req=%b cause=%b, want 1 x5=00001234",
               wb_en, wb_addr, wb_data, stall_mw, dbus_req, exc_cause);
    end
    @(negedge clk);
    set_alu(32'hFFFF_FFFC, 32'h5555_0000, 5'd31, 1'b1, 2'b10);
    #1;
    n_tests++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd31, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL alu pc+4 wrap: en=%b x%0d=%h want 1 x31=00000000", wb_en, wb_addr, wb_data);
    end
    @(negedge clk);
    set_alu(32'h0000_0200, 32'hCAFE_F00D, 5'd9, 1'b1, 2'b11);
    #1;
    n_tests++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd9, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL alu sel11: en=%b x%0d=%h want 1 x9=cafef00d", wb_en, wb_addr, wb_data);
    end
    @(negedge clk);
    set_alu(32'h0000_0200, 32'h0000_0077, 5'd0, 1'b1, 2'b00);
    #1;
    n_tests++;
    if (wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL alu rd0: wb_en got %b want 0", wb_en);
    end
    @(negedge clk);
    set_alu(32'h0000_0200, 32'h0000_0077, 5'd4, 1'b0, 2'b00);
    #1;
    n_tests++;
    if (wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL alu no reg_wr: wb_en got %b want 0", wb_en);
    end
  endtask

  task automatic test_load_lb;
    int cyc;
    do_memop(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 0, 0,
             32'h80FF_FF7F, "lb", cyc);
    n_tests++;
    if (cyc !== 4) begin
      n_fail++;
      $display("FAIL lb occupancy: got %0d cycles want 4", cyc);
    end
  endtask

  task automatic test_store_sh;
    int cyc;
    do_memop(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1'b1, 3, 1,
             32'h0, "sh", cyc);
    do_memop(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A7, 5'd0, 1'b0, 0, 0,
             32'h0, "sb", cyc);
    do_memop(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344, 5'd0, 1'b0, 1, 2,
             32'h0, "sw", cyc);
  endtask

  task automatic test_loads;
    int cyc;
    do_memop(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd10, 1'b1, 0, 2,
             32'h8001_7FFF, "lh", cyc);
    do_memop(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd11, 1'b1, 1, 0,
             32'h8001_7FFF, "lhu", cyc);
    do_memop(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd12, 1'b1, 0, 0,
             32'h0000_8000, "lbu", cyc);
    do_memop(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 5'd13, 1'b1, 0, 0,
             32'h1234_7FFE, "lh_lo", cyc);
    do_memop(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd14, 1'b1, 2, 3,
             32'hA5A5_5A5A, "lw", cyc);
    do_memop(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 5'd0, 1'b1, 0, 0,
             32'hFFFF_FFFF, "lw_rd0", cyc);
  endtask

  task automatic test_exc;
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd2, 1'b1);
    #1;
    n_tests++;
    if ({mem_exc, exc_cause, dbus_req, wb_en, stall_mw} !== {1'b1, 2'b01, 3'b000}) begin
      n_fail++;
      $display("FAIL lw misaligned: exc=%b cause=%b req=%b wb=%b stall=%b want 1 01 0 0 0",
               mem_exc, exc_cause, dbus_req, wb_en, stall_mw);
    end
    @(negedge clk);
    set_alu(32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    #1;
    n_tests++;
    if ({mem_exc, exc_cause, dbus_req} !== {1'b0, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL cause hold: exc=%b cause=%b req=%b want 0 01 0", mem_exc, exc_cause, dbus_req);
    end
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b011, 32'h0000_0101, 32'h0, 5'd2, 1'b1);
    #1;
    n_tests++;
    if ({mem_exc, exc_cause, dbus_req, wb_en, stall_mw} !== {1'b1, 2'b10, 3'b000}) begin
      n_fail++;
      $display("FAIL illegal f3 priority: exc=%b cause=%b want 1 10", mem_exc, exc_cause);
    end
    @(negedge clk);
    set_mem(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0, 5'd0, 1'b0);
    #1;
    n_tests++;
    if ({mem_exc, exc_cause, dbus_req} !== {1'b1, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL sh misaligned: exc=%b cause=%b want 1 01", mem_exc, exc_cause);
    end
    @(negedge clk);
    set_mem(1'b0, 1'b1, 3'b110, 32'h0000_0200, 32'h0, 5'd0, 1'b0);
    #1;
    n_tests++;
    if ({mem_exc, exc_cause, dbus_req} !== {1'b1, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL store illegal f3: exc=%b cause=%b want 1 10", mem_exc, exc_cause);
    end
    @(negedge clk);
    set_alu(32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    #1;
    n_tests++;
    if ({dbus_req, stall_mw, mem_exc} !== 3'b000) begin
      n_fail++;
      $display("FAIL exc stays idle: req/stall/exc got %b want 000", {dbus_req, stall_mw, mem_exc});
    end
  endtask

  task automatic test_timeout;
    int k;
    int bad;
    bad = 0;
    k   = 0;
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd8, 1'b1);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      #1;
      if (mem_exc === 1'b1) begin
        k = i;
        break;
      end
      if ({dbus_req, stall_mw, wb_en} !== 3'b110) bad++;
    end
    n_tests++;
    if (k !== 255) begin
      n_fail++;
      $display("FAIL timeout cycle: mem_exc at REQ cycle %0d want 255", k);
    end
    n_tests++;
    if ({exc_cause, stall_mw, wb_en, bad} !== {2'b11, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL timeout state: cause=%b stall=%b wb_en=%b bad_wait_cycles=%0d want 11 0 0 0",
               exc_cause, stall_mw, wb_en, bad);
    end
    @(negedge clk);
    set_alu(32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    #1;
    n_tests++;
    if ({dbus_req, stall_mw, mem_exc, exc_cause} !== {3'b000, 2'b11}) begin
      n_fail++;
      $display("FAIL after timeout: req/stall/exc/cause got %b want 00011",
               {dbus_req, stall_mw, mem_exc, exc_cause});
    end
  endtask

  task automatic test_reset_in_rsp;
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 1'b1);
    @(negedge clk);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    rst      = 1'b1;
    #1;
    n_tests++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_mw, wb_en, wb_addr, wb_data,
         mem_exc, exc_cause} !== '0) begin
      n_fail++;
      $display("FAIL reset in rsp: stall=%b req=%b wb_en=%b cause=%b want all 0",
               stall_mw, dbus_req, wb_en, exc_cause);
    end
    @(negedge clk);
    rst         = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'h0000_0080;
    set_alu(32'h0, 32'h0, 5'd6, 1'b0, 2'b00);
    #1;
    n_tests++;
    if ({stall_mw, dbus_req, wb_en, mem_exc, exc_cause} !== 6'd0) begin
      n_fail++;
      $display("FAIL late rvalid: stall/req/wb/exc/cause got %b want 000000",
               {stall_mw, dbus_req, wb_en, mem_exc, exc_cause});
    end
    @(negedge clk);
    dbus_rvalid = 1'b0;
    set_alu(32'h0, 32'h0000_A5A5, 5'd7, 1'b1, 2'b00);
    #1;
    n_tests++;
    if ({wb_en, wb_addr, wb_data, stall_mw} !== {1'b1, 5'd7, 32'h0000_A5A5, 1'b0}) begin
      n_fail++;
      $display("FAIL idle after reset: en=%b x%0d=%h stall=%b want 1 x7=0000a5a5 0",
               wb_en, wb_addr, wb_data, stall_mw);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    do_memop(1'b1, 1'b0, 3'b000, 32'h0000_0600, 32'h0, 5'd20, 1'b1, 0, 0,
             32'h0000_00FE, "b2b_lb", cyc);
    do_memop(1'b0, 1'b1, 3'b010, 32'h0000_0604, 32'hFACE_0001, 5'd0, 1'b0, 0, 0,
             32'h0, "b2b_sw", cyc);
    do_memop(1'b1, 1'b0, 3'b101, 32'h0000_0606, 32'h0, 5'd21, 1'b1, 0, 1,
             32'hBEEF_0000, "b2b_lhu", cyc);
    @(negedge clk);
    set_alu(32'h0000_0040, 32'h0, 5'd1, 1'b1, 2'b10);
    #1;
    n_tests++;
    if ({wb_en, wb_addr, wb_data, stall_mw} !== {1'b1, 5'd1, 32'h0000_0044, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b alu: en=%b x%0d=%h stall=%b want 1 x1=00000044 0",
               wb_en, wb_addr, wb_data, stall_mw);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_lb();
    test_store_sh();
    test_loads();
    test_exc();
    test_timeout();
    test_reset_in_rsp();
    test_back_to_back();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d writebacks pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
